// File: rtl/vga_fb_fill_ram_pkg.sv
// Shared types and helpers for the framebuffer with hardware fill engine.
package vga_fb_pkg;

  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

  function automatic logic in_range(input int unsigned row, input int unsigned col,
                                    input int unsigned width, input int unsigned height);
    return (row < height) && (col < width);
  endfunction

endpackage

// File: rtl/vga_fb_fill_ram_if.sv
// CPU/VGA-side bus of the framebuffer: CPU port, VGA scan read port and fill control.
interface vga_fb_fill_ram_if #(
  parameter int ADDR_BITS = 13,
  parameter int PIX_BITS  = 8
);
  logic                 WE;
  logic [ADDR_BITS-1:0] WA1;
  logic [PIX_BITS-1:0]  WD;
  logic [PIX_BITS-1:0]  RD1;
  logic [ADDR_BITS-1:0] RA2;
  logic [PIX_BITS-1:0]  RD2;
  logic                 FILL_START;
  logic [PIX_BITS-1:0]  FILL_COLOR;
  logic                 FILL_BUSY;
  logic                 FILL_DONE;

  modport master (
    output WE, WA1, WD, RA2, FILL_START, FILL_COLOR,
    input  RD1, RD2, FILL_BUSY, FILL_DONE
  );

  modport slave (
    input  WE, WA1, WD, RA2, FILL_START, FILL_COLOR,
    output RD1, RD2, FILL_BUSY, FILL_DONE
  );
endinterface

// File: rtl/vga_fb_fill_ram_dpram.sv
// Pixel store: one write port and two synchronous read-first read ports (block RAM).
module fb_dpram #(
  parameter int DEPTH     = 7632,
  parameter int ADDR_BITS = 13,
  parameter int PIX_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wa,
  input  logic [PIX_BITS-1:0]  wd,
  input  logic [ADDR_BITS-1:0] ra1,
  input  logic [ADDR_BITS-1:0] ra2,
  output logic [PIX_BITS-1:0]  rd1,
  output logic [PIX_BITS-1:0]  rd2
);
  logic [PIX_BITS-1:0] mem [0:DEPTH-1];

  // Reads sample the array before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd1 <= mem[ra1];
    rd2 <= mem[ra2];
  end
endmodule

// File: rtl/vga_fb_fill_ram.sv
// Framebuffer with CPU and VGA read ports plus a fill engine painting every visible pixel.
module vga_fb_fill_ram
  import vga_fb_pkg::*;
#(
  parameter int WIDTH    = 80,
  parameter int HEIGHT   = 60,
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 6,
  parameter int PIX_BITS = 8
) (
  input  logic              CLK_50MHz,
  input  logic              RST,
  vga_fb_fill_ram_if.slave  bus
);
  localparam int ADDR_BITS = ROW_BITS + COL_BITS;
  localparam int DEPTH     = (HEIGHT - 1) * 2**COL_BITS + WIDTH;

  fill_state_t           state_reg, state_next;
  logic [ROW_BITS-1:0]   row_reg, row_next;
  logic [COL_BITS-1:0]   col_reg, col_next;
  logic [PIX_BITS-1:0]   color_reg, color_next;
  logic                  rd1_ok_reg, rd2_ok_reg;
  logic                  fill_we, fill_last;
  logic                  cpu_ok, ra2_ok;
  logic                  ram_we;
  logic [ADDR_BITS-1:0]  ram_wa, ram_ra1, ram_ra2;
  logic [PIX_BITS-1:0]   ram_wd, ram_rd1, ram_rd2;

  assign cpu_ok = in_range(32'(bus.WA1[ADDR_BITS-1:COL_BITS]), 32'(bus.WA1[COL_BITS-1:0]),
                           WIDTH, HEIGHT);
  assign ra2_ok = in_range(32'(bus.RA2[ADDR_BITS-1:COL_BITS]), 32'(bus.RA2[COL_BITS-1:0]),
                           WIDTH, HEIGHT);
  assign fill_last = (row_reg == ROW_BITS'(HEIGHT - 1)) && (col_reg == COL_BITS'(WIDTH - 1));

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    color_next = color_reg;
    fill_we    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.FILL_START) begin
          color_next = bus.FILL_COLOR;
          row_next   = '0;
          col_next   = '0;
          state_next = FILL;
        end
      end
      FILL: begin
        // Any CPU write, even an out-of-range one, stalls the fill for this cycle.
        if (!bus.WE) begin
          fill_we = 1'b1;
          if (fill_last) begin
            state_next = DONE;
          end else if (col_reg == COL_BITS'(WIDTH - 1)) begin
            col_next = '0;
            row_next = row_reg + 1'b1;
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHz) begin
    if (RST) begin
      state_reg  <= IDLE;
      row_reg    <= '0;
      col_reg    <= '0;
      color_reg  <= '0;
      rd1_ok_reg <= 1'b0;
      rd2_ok_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      row_reg    <= row_next;
      col_reg    <= col_next;
      color_reg  <= color_next;
      rd1_ok_reg <= cpu_ok;
      rd2_ok_reg <= ra2_ok;
    end
  end

  // Reset suppresses the pending fill write so an aborted fill leaves the current pixel intact.
  assign ram_we  = (bus.WE && cpu_ok) || (fill_we && !RST);
  assign ram_wa  = bus.WE ? bus.WA1 : {row_reg, col_reg};
  assign ram_wd  = bus.WE ? bus.WD  : color_reg;
  assign ram_ra1 = cpu_ok ? bus.WA1 : '0;
  assign ram_ra2 = ra2_ok ? bus.RA2 : '0;

  fb_dpram #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS),
    .PIX_BITS  (PIX_BITS)
  ) u_ram (
    .clk (CLK_50MHz),
    .we  (ram_we),
    .wa  (ram_wa),
    .wd  (ram_wd),
    .ra1 (ram_ra1),
    .ra2 (ram_ra2),
    .rd1 (ram_rd1),
    .rd2 (ram_rd2)
  );

  assign bus.RD1       = rd1_ok_reg ? ram_rd1 : '0;
  assign bus.RD2       = rd2_ok_reg ? ram_rd2 : '0;
  assign bus.FILL_BUSY = (state_reg == FILL);
  assign bus.FILL_DONE = (state_reg == DONE);
endmodule

// File: tb/tb_vga_fb_fill_ram.sv
// Directed + randomized bench for vga_fb_fill_ram against a raster-order pixel model.
module tb_vga_fb_fill_ram;
  localparam int WIDTH = 80, HEIGHT = 60, COL_BITS = 7, ROW_BITS = 6, PIX_BITS = 8;
  localparam int ADDR_BITS = ROW_BITS + COL_BITS;
  localparam int STRIDE = 2**COL_BITS;
  localparam int NPIX = WIDTH * HEIGHT;

  logic CLK_50MHz = 1'b0;
  logic RST;
  always #10 CLK_50MHz = ~CLK_50MHz;

  vga_fb_fill_ram_if #(.ADDR_BITS(ADDR_BITS), .PIX_BITS(PIX_BITS)) bus ();

  vga_fb_fill_ram #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .PIX_BITS(PIX_BITS)
  ) dut (
    .CLK_50MHz (CLK_50MHz),
    .RST       (RST),
    .bus       (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] ref_mem [0:(1<<ADDR_BITS)-1];

  function automatic logic [ADDR_BITS-1:0] pa(input int row, input int col);
    return ADDR_BITS'(row * STRIDE + col);
  endfunction

  function automatic logic visible(input logic [ADDR_BITS-1:0] a);
    int r, c;
    r = 32'(a) / STRIDE;
    c = 32'(a) % STRIDE;
    return (r < HEIGHT) && (c < WIDTH);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [ADDR_BITS-1:0] a);
    return visible(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic tick();
    @(posedge CLK_50MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
    $display("check %-14s observed %02h expected %02h", tag, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cpu_write(input logic [ADDR_BITS-1:0] a, input logic [7:0] d);
    bus.WE = 1'b1; bus.WA1 = a; bus.WD = d;
    tick();
    bus.WE = 1'b0;
    if (visible(a)) ref_mem[a] = d;
  endtask

  task automatic read_chk(input string tag, input logic [ADDR_BITS-1:0] a);
    bus.WE = 1'b0; bus.WA1 = a; bus.RA2 = a;
    tick();
    chk({tag, "/rd1"}, bus.RD1, ref_rd(a));
    chk({tag, "/rd2"}, bus.RD2, ref_rd(a));
  endtask

  // Pixels are painted in raster order, one per cycle that carries no CPU write.
  task automatic run_fill(input logic [7:0] color, input int stalls, input logic rand_addr,
                          input logic [ADDR_BITS-1:0] st_addr, input logic [7:0] st_data,
                          input int restart_at, output int busy, output int dones);
    int painted, left;
    logic s;
    logic [ADDR_BITS-1:0] a;
    logic [7:0] d;
    painted = 0; left = stalls; busy = 0; dones = 0;
    bus.FILL_START = 1'b1; bus.FILL_COLOR = color;
    tick();
    bus.FILL_START = 1'b0; bus.FILL_COLOR = 8'($urandom);
    for (int cyc = 0; cyc < 20000 && bus.FILL_BUSY; cyc++) begin
      busy++;
      s = (left > 0) && (($urandom_range(0, 299) == 0) || (painted >= NPIX - left));
      a = rand_addr ? ADDR_BITS'($urandom) : st_addr;
      d = rand_addr ? 8'($urandom) : st_data;
      if (s) begin
        bus.WE = 1'b1; bus.WA1 = a; bus.WD = d;
      end
      bus.FILL_START = (busy == restart_at);
      bus.FILL_COLOR = ~color;
      tick();
      bus.WE = 1'b0; bus.FILL_START = 1'b0;
      if (s) begin
        left--;
        if (visible(a)) ref_mem[a] = d;
      end else if (painted < NPIX) begin
        ref_mem[pa(painted / WIDTH, painted % WIDTH)] = color;
        painted++;
      end
    end
    chk("fill_ended", {7'd0, bus.FILL_BUSY}, 8'h00);
    chk("done_pulse", {7'd0, bus.FILL_DONE}, 8'h01);
    if (bus.FILL_DONE) dones++;
    // A start request landing in DONE must be dropped.
    bus.FILL_START = (restart_at > 0);
    tick();
    bus.FILL_START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.FILL_DONE || bus.FILL_BUSY) dones++;
      tick();
    end
  endtask

  initial begin
    int busy, dones;
    logic [ADDR_BITS-1:0] wa, ra;
    logic [7:0] wd, exp1, exp2;
    logic we;

    for (int i = 0; i < (1 << ADDR_BITS); i++) ref_mem[i] = 8'h00;
    RST = 1'b1;
    bus.WE = 1'b0; bus.WA1 = '0; bus.WD = '0; bus.RA2 = '0;
    bus.FILL_START = 1'b0; bus.FILL_COLOR = '0;
    repeat (3) tick();
    chk("rst_rd1", bus.RD1, 8'h00);
    chk("rst_rd2", bus.RD2, 8'h00);
    chk("rst_busy", {7'd0, bus.FILL_BUSY}, 8'h00);
    chk("rst_done", {7'd0, bus.FILL_DONE}, 8'h00);
    RST = 1'b0;
    tick();

    // Basic write then read on both ports.
    cpu_write(pa(3, 5), 8'hA5);
    read_chk("wr_rd", pa(3, 5));
    chk("wr_rd_const", bus.RD1, 8'hA5);

    // Range handling at the visible boundary.
    cpu_write(pa(0, 79), 8'h11);
    cpu_write(pa(1, 0), 8'h22);
    cpu_write(pa(0, 100), 8'hFF);
    cpu_write(pa(60, 0), 8'hFF);
    read_chk("col100", pa(0, 100));
    read_chk("row60", pa(60, 0));
    read_chk("edge_0_79", pa(0, 79));
    read_chk("edge_1_0", pa(1, 0));

    // Same-cycle write and read returns the old value.
    bus.WE = 1'b1; bus.WA1 = pa(3, 5); bus.WD = 8'h3C; bus.RA2 = pa(3, 5);
    tick();
    bus.WE = 1'b0;
    chk("rd_first1", bus.RD1, 8'hA5);
    chk("rd_first2", bus.RD2, 8'hA5);
    ref_mem[pa(3, 5)] = 8'h3C;
    read_chk("after_rf", pa(3, 5));

    // Random traffic clustered around the bottom-right boundary.
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom);
      wa = pa($urandom_range(57, 62), $urandom_range(75, 84));
      ra = pa($urandom_range(57, 62), $urandom_range(75, 84));
      wd = 8'($urandom);
      exp1 = ref_rd(wa); exp2 = ref_rd(ra);
      bus.WE = we; bus.WA1 = wa; bus.WD = wd; bus.RA2 = ra;
      tick();
      bus.WE = 1'b0;
      chk("rand_rd1", bus.RD1, exp1);
      chk("rand_rd2", bus.RD2, exp2);
      if (we && visible(wa)) ref_mem[wa] = wd;
    end

    // Unstalled fill with a start request ignored mid-fill.
    run_fill(8'h1C, 0, 1'b0, '0, '0, 100, busy, dones);
    chk_int("fill_busy", busy, NPIX);
    chk_int("fill_dones", dones, 1);
    read_chk("f_0_0", pa(0, 0));
    read_chk("f_59_79", pa(59, 79));
    read_chk("f_30_40", pa(30, 40));
    read_chk("f_gap80", pa(0, 80));
    chk("f_59_79_c", bus.RD1, 8'h00);

    // Stalled fill: ten CPU writes of E0 to the last pixel.
    run_fill(8'h1C, 10, 1'b0, pa(59, 79), 8'hE0, 0, busy, dones);
    chk_int("stall_busy", busy, NPIX + 10);
    chk_int("stall_dones", dones, 1);
    read_chk("s_59_79", pa(59, 79));
    chk("s_59_79_c", bus.RD1, 8'h1C);

    // Randomized fill with random-address CPU writes interleaved.
    run_fill(8'($urandom), 25, 1'b1, '0, '0, 0, busy, dones);
    chk_int("rfill_busy", busy, NPIX + 25);
    chk_int("rfill_dones", dones, 1);
    for (int i = 0; i < 20; i++) read_chk("rfill_pix", pa($urandom_range(0, 63), $urandom_range(0, 127)));

    // Reset during busy cycle 200 (row 2, col 40).
    bus.FILL_START = 1'b1; bus.FILL_COLOR = 8'h5A;
    tick();
    bus.FILL_START = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      ref_mem[pa(i / WIDTH, i % WIDTH)] = 8'h5A;
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_mid_busy", {7'd0, bus.FILL_BUSY}, 8'h00);
    chk("rst_mid_done", {7'd0, bus.FILL_DONE}, 8'h00);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.FILL_DONE) dones++;
      tick();
    end
    chk_int("rst_no_done", dones, 0);
    read_chk("r_2_39", pa(2, 39));
    chk("r_2_39_c", bus.RD1, 8'h5A);
    read_chk("r_2_40", pa(2, 40));
    read_chk("r_59_79", pa(59, 79));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
